// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage registers.
// Control-word bit positions and the per-boundary kill masks live here.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

    localparam int CTRL_REGWRITE    = 0;
    localparam int CTRL_MEMWRITE    = 1;
    localparam int CTRL_JUMP        = 2;
    localparam int CTRL_BRANCH      = 3;
    localparam int CTRL_MEMREAD     = 4;
    localparam int CTRL_ALUSRC      = 5;
    localparam int CTRL_RESULTSRC   = 6;
    localparam int CTRL_ALUCTRL_LSB = 8;
    localparam int CTRL_ALUCTRL_W   = 3;

    // Bits that must never fire from a bubble; later stages only retain what they still act on.
    localparam logic [15:0] KILL_FD = 16'h000F;
    localparam logic [15:0] KILL_DE = 16'h000F;
    localparam logic [15:0] KILL_EM = 16'h0003;
    localparam logic [15:0] KILL_MW = 16'h0001;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!clr_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: main entry plus one skid entry, stall/flush
// from the hazard unit, and a saturating count of bubble cycles for perf debug.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                    CTRL_WIDTH = 16,
    parameter int                    DATA_WIDTH = 192,
    parameter logic [CTRL_WIDTH-1:0] KILL_MASK  = 16'h000F,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  bubble_cnt
);

    occ_state_t            state_q, state_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

    logic main_valid, skid_valid, take, accept;

    assign main_valid = (state_q != OCC_EMPTY);
    assign skid_valid = (state_q == OCC_FULL);
    assign in_ready   = ~skid_valid;
    assign take       = main_valid & out_ready & ~stall;
    assign accept     = in_valid & in_ready & ~flush;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = OCC_EMPTY;
            main_ctrl_d = main_ctrl_q & ~KILL_MASK;
            skid_ctrl_d = skid_ctrl_q & ~KILL_MASK;
        end else begin
            unique case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        state_d     = OCC_ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                OCC_ONE: begin
                    if (accept && take) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept) begin
                        state_d     = OCC_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (take) begin
                        // Draining to a bubble: kill bits drop together with valid.
                        state_d     = OCC_EMPTY;
                        main_ctrl_d = main_ctrl_q & ~KILL_MASK;
                    end
                end
                OCC_FULL: begin
                    if (take) begin
                        state_d     = OCC_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= OCC_EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc_i (~main_valid),
        .cnt_o (bubble_cnt)
    );

endmodule
